// File: rtl/sf_pattern_engine.sv
// Flash pattern engine: generates a start/increment byte sequence for programming and checks read-back data.
// Optional first-mismatch capture is enabled with the SF_PATTERN_FIRST_ERR_CAPTURE_EN macro.
module sf_pattern_engine #(
  parameter logic [31:0] P_CHECK_LEN = 32'd1048576,
  parameter int unsigned P_ERR_CNT_W = 32
) (
  input  logic                   i_clk_40mhz,
  input  logic                   i_rstn_40mhz,
  input  logic [1:0]             i_pattern_sel,
  input  logic                   i_start,
  input  logic                   i_tx_ack,
  output logic [7:0]             o_tx_byte,
  input  logic                   i_rx_valid,
  input  logic [7:0]             i_rx_byte,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_pass,
  output logic [P_ERR_CNT_W-1:0] o_err_count,
  output logic [31:0]            o_rx_count,
  output logic [31:0]            o_first_err_idx,
  output logic [7:0]             o_first_err_exp,
  output logic [7:0]             o_first_err_act
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic logic [7:0] pat_start(input logic [1:0] sel);
    case (sel)
      2'd0:    pat_start = 8'h00;
      2'd1:    pat_start = 8'h08;
      2'd2:    pat_start = 8'h10;
      2'd3:    pat_start = 8'h18;
      default: pat_start = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] pat_inc(input logic [1:0] sel);
    case (sel)
      2'd0:    pat_inc = 8'h01;
      2'd1:    pat_inc = 8'h07;
      2'd2:    pat_inc = 8'h0F;
      2'd3:    pat_inc = 8'h17;
      default: pat_inc = 8'h01;
    endcase
  endfunction

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [1:0]             sel_r;
  logic [7:0]             inc_s;
  logic [7:0]             tx_r;
  logic [7:0]             exp_r;
  logic [P_ERR_CNT_W-1:0] err_cnt_r;
  logic [P_ERR_CNT_W-1:0] err_cnt_nxt_s;
  logic [31:0]            rx_cnt_r;
  logic                   done_r;
  logic                   pass_r;
  logic                   tx_take_s;
  logic                   rx_take_s;
  logic                   mismatch_s;
  logic                   last_rx_s;

  assign inc_s = pat_inc(sel_r);

  // Qualify the datapath strobes and compute the next FSM state; a start always wins over data
  always_comb begin
    state_nxt_s   = state_r;
    tx_take_s     = (state_r == ST_ACTIVE) && i_tx_ack && !i_start;
    rx_take_s     = (state_r == ST_ACTIVE) && i_rx_valid && !i_start;
    mismatch_s    = rx_take_s && (i_rx_byte != exp_r);
    last_rx_s     = rx_take_s && ((rx_cnt_r + 32'd1) == P_CHECK_LEN);
    err_cnt_nxt_s = err_cnt_r;
    if (mismatch_s && (err_cnt_r != {P_ERR_CNT_W{1'b1}})) begin
      err_cnt_nxt_s = err_cnt_r + P_ERR_CNT_W'(1);
    end else begin
      err_cnt_nxt_s = err_cnt_r;
    end
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_nxt_s = ST_ACTIVE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_ACTIVE: begin
        if (i_start) begin
          state_nxt_s = ST_ACTIVE;
        end else if (last_rx_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, generators, counters and run result
  always_ff @(posedge i_clk_40mhz or negedge i_rstn_40mhz) begin
    if (!i_rstn_40mhz) begin
      state_r   <= ST_IDLE;
      sel_r     <= 2'd0;
      tx_r      <= 8'h00;
      exp_r     <= 8'h00;
      err_cnt_r <= {P_ERR_CNT_W{1'b0}};
      rx_cnt_r  <= 32'd0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= last_rx_s;
      if (i_start) begin
        sel_r     <= i_pattern_sel;
        tx_r      <= pat_start(i_pattern_sel);
        exp_r     <= pat_start(i_pattern_sel);
        err_cnt_r <= {P_ERR_CNT_W{1'b0}};
        rx_cnt_r  <= 32'd0;
      end else begin
        if (tx_take_s) begin
          tx_r <= tx_r + inc_s;
        end
        if (rx_take_s) begin
          exp_r     <= exp_r + inc_s;
          rx_cnt_r  <= rx_cnt_r + 32'd1;
          err_cnt_r <= err_cnt_nxt_s;
        end
      end
      if (last_rx_s) begin
        pass_r <= ~|err_cnt_nxt_s;
      end
    end
  end

  assign o_tx_byte   = tx_r;
  assign o_busy      = (state_r == ST_ACTIVE);
  assign o_done      = done_r;
  assign o_pass      = pass_r;
  assign o_err_count = err_cnt_r;
  assign o_rx_count  = rx_cnt_r;

`ifdef SF_PATTERN_FIRST_ERR_CAPTURE_EN
  logic        first_seen_r;
  logic [31:0] first_idx_r;
  logic [7:0]  first_exp_r;
  logic [7:0]  first_act_r;

  // Capture the first mismatch of a run; held until the next start
  always_ff @(posedge i_clk_40mhz or negedge i_rstn_40mhz) begin
    if (!i_rstn_40mhz) begin
      first_seen_r <= 1'b0;
      first_idx_r  <= 32'd0;
      first_exp_r  <= 8'h00;
      first_act_r  <= 8'h00;
    end else if (i_start) begin
      first_seen_r <= 1'b0;
      first_idx_r  <= 32'd0;
      first_exp_r  <= 8'h00;
      first_act_r  <= 8'h00;
    end else if (mismatch_s && !first_seen_r) begin
      first_seen_r <= 1'b1;
      first_idx_r  <= rx_cnt_r;
      first_exp_r  <= exp_r;
      first_act_r  <= i_rx_byte;
    end
  end

  assign o_first_err_idx = first_idx_r;
  assign o_first_err_exp = first_exp_r;
  assign o_first_err_act = first_act_r;
`else
  assign o_first_err_idx = 32'd0;
  assign o_first_err_exp = 8'h00;
  assign o_first_err_act = 8'h00;
`endif

endmodule

// File: tb/tb_sf_pattern_engine.sv
// Self-checking bench for sf_pattern_engine: directed scenarios plus random traffic against a
// sequence-arithmetic reference model.
module tb_sf_pattern_engine;

  localparam int CHECK_LEN = 8;
  localparam int ERR_W     = 3;
  localparam int ERR_MAX   = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [1:0]       i_pattern_sel = 2'd0;
  logic             i_start = 1'b0;
  logic             i_tx_ack = 1'b0;
  logic [7:0]       o_tx_byte;
  logic             i_rx_valid = 1'b0;
  logic [7:0]       i_rx_byte = 8'h00;
  logic             o_busy;
  logic             o_done;
  logic             o_pass;
  logic [ERR_W-1:0] o_err_count;
  logic [31:0]      o_rx_count;
  logic [31:0]      o_first_err_idx;
  logic [7:0]       o_first_err_exp;
  logic [7:0]       o_first_err_act;

  sf_pattern_engine #(.P_CHECK_LEN(32'(CHECK_LEN)), .P_ERR_CNT_W(ERR_W)) dut (
    .i_clk_40mhz(clk), .i_rstn_40mhz(rst_n), .i_pattern_sel(i_pattern_sel),
    .i_start(i_start), .i_tx_ack(i_tx_ack), .o_tx_byte(o_tx_byte),
    .i_rx_valid(i_rx_valid), .i_rx_byte(i_rx_byte), .o_busy(o_busy),
    .o_done(o_done), .o_pass(o_pass), .o_err_count(o_err_count),
    .o_rx_count(o_rx_count), .o_first_err_idx(o_first_err_idx),
    .o_first_err_exp(o_first_err_exp), .o_first_err_act(o_first_err_act)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // Reference model: run status plus counts of acks and checked bytes since start
  int m_state = 0;  // 0 idle, 1 active, 2 done
  int m_sel   = 0;
  int m_tx_n  = 0;
  int m_rx_n  = 0;
  int m_err   = 0;
  bit m_pass  = 1'b0;
  bit m_done  = 1'b0;
  bit m_first = 1'b0;
  int m_fidx  = 0;
  int m_fexp  = 0;
  int m_fact  = 0;

  function automatic int start_of(input int sel);
    return sel * 8;
  endfunction

  function automatic int inc_of(input int sel);
    return (sel == 0) ? 1 : sel * 8 - 1;
  endfunction

  function automatic logic [7:0] seq_byte(input int sel, input int n);
    return 8'((start_of(sel) + n * inc_of(sel)) % 256);
  endfunction

  task automatic model_reset();
    m_state = 0; m_sel = 0; m_tx_n = 0; m_rx_n = 0; m_err = 0;
    m_pass = 1'b0; m_done = 1'b0; m_first = 1'b0; m_fidx = 0; m_fexp = 0; m_fact = 0;
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      m_done = 1'b0;
      if (i_start) begin
        m_state = 1; m_sel = int'(i_pattern_sel); m_tx_n = 0; m_rx_n = 0; m_err = 0;
        m_first = 1'b0; m_fidx = 0; m_fexp = 0; m_fact = 0;
      end else if (m_state == 1) begin
        if (i_tx_ack) m_tx_n++;
        if (i_rx_valid) begin
          if (i_rx_byte != seq_byte(m_sel, m_rx_n)) begin
            if (m_err < ERR_MAX) m_err++;
            if (!m_first) begin
              m_first = 1'b1; m_fidx = m_rx_n;
              m_fexp = int'(seq_byte(m_sel, m_rx_n)); m_fact = int'(i_rx_byte);
            end
          end
          m_rx_n++;
          if (m_rx_n == CHECK_LEN) begin
            m_state = 2; m_done = 1'b1; m_pass = (m_err == 0);
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [7:0]  e_tx;
      logic [31:0] e_fidx;
      logic [7:0]  e_fexp, e_fact;
      e_tx = seq_byte(m_sel, m_tx_n);
`ifdef SF_PATTERN_FIRST_ERR_CAPTURE_EN
      e_fidx = 32'(m_fidx); e_fexp = 8'(m_fexp); e_fact = 8'(m_fact);
`else
      e_fidx = 32'd0; e_fexp = 8'h00; e_fact = 8'h00;
`endif
      n_checks++;
      if (o_tx_byte == e_tx && o_busy == (m_state == 1) && o_done == m_done &&
          o_pass == m_pass && o_err_count == ERR_W'(m_err) && o_rx_count == 32'(m_rx_n) &&
          o_first_err_idx == e_fidx && o_first_err_exp == e_fexp && o_first_err_act == e_fact)
        n_pass++;
      else
        $display("FAIL cycle_cmp t=%0t got tx=%h busy=%b done=%b pass=%b err=%0d rx=%0d fe=%0d/%h/%h want tx=%h busy=%b done=%b pass=%b err=%0d rx=%0d fe=%0d/%h/%h",
                 $time, o_tx_byte, o_busy, o_done, o_pass, o_err_count, o_rx_count,
                 o_first_err_idx, o_first_err_exp, o_first_err_act, e_tx, (m_state == 1),
                 m_done, m_pass, m_err, m_rx_n, e_fidx, e_fexp, e_fact);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s got %0h want %0h", name, act, exp);
  endtask

  task automatic cyc(input logic st, input logic [1:0] sel, input logic ack,
                     input logic rv, input logic [7:0] rb);
    i_start = st; i_pattern_sel = sel; i_tx_ack = ack; i_rx_valid = rv; i_rx_byte = rb;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0; i_tx_ack = 1'b0; i_rx_valid = 1'b0; i_rx_byte = 8'h00;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tx"}, 64'(o_tx_byte), 64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
    chk({tag, "_pass"}, 64'(o_pass), 64'd0);
    chk({tag, "_err"}, 64'(o_err_count), 64'd0);
    chk({tag, "_rx"}, 64'(o_rx_count), 64'd0);
    chk({tag, "_fe"}, 64'({o_first_err_idx, o_first_err_exp, o_first_err_act}), 64'd0);
  endtask

  logic [7:0] d_seq [0:11];
  logic [7:0] b_rx  [0:7];

  initial begin
    d_seq = '{8'h18, 8'h2F, 8'h46, 8'h5D, 8'h74, 8'h8B, 8'hA2, 8'hB9, 8'hD0, 8'hE7, 8'hFE, 8'h15};
    b_rx  = '{8'h08, 8'h0F, 8'hFF, 8'h1D, 8'h24, 8'h2B, 8'h32, 8'h39};

    #1 rst_n = 1'b0;
    model_reset();
    #1 chk_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Pattern A: tx steps one per ack, then eight correct read-backs
    cyc(1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      chk("a_tx_step", 64'(o_tx_byte), 64'(i));
      cyc(1'b0, 2'd0, 1'b1, 1'b0, 8'h00);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("a_no_early_done", 64'(o_done), 64'd0);
      cyc(1'b0, 2'd0, 1'b0, 1'b1, 8'(i));
    end
    chk("a_done", 64'(o_done), 64'd1);
    chk("a_pass", 64'(o_pass), 64'd1);
    chk("a_err", 64'(o_err_count), 64'd0);
    chk("a_rx", 64'(o_rx_count), 64'd8);
    chk("a_busy", 64'(o_busy), 64'd0);
    cyc(1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
    chk("a_done_single", 64'(o_done), 64'd0);

    // Pattern D wraps past 0xFF
    cyc(1'b1, 2'd3, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 12; k++) begin
      chk("d_tx_seq", 64'(o_tx_byte), 64'(d_seq[k]));
      cyc(1'b0, 2'd3, 1'b1, 1'b0, 8'h00);
    end

    // Pattern B with one corrupted byte at index 2
    cyc(1'b1, 2'd1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 8; k++) cyc(1'b0, 2'd1, 1'b0, 1'b1, b_rx[k]);
    chk("b_done", 64'(o_done), 64'd1);
    chk("b_err", 64'(o_err_count), 64'd1);
    chk("b_pass", 64'(o_pass), 64'd0);
`ifdef SF_PATTERN_FIRST_ERR_CAPTURE_EN
    chk("b_first", 64'({o_first_err_idx, o_first_err_exp, o_first_err_act}), {16'd0, 32'd2, 8'h16, 8'hFF});
`else
    chk("b_first", 64'({o_first_err_idx, o_first_err_exp, o_first_err_act}), 64'd0);
`endif

    // Every byte wrong: error count saturates
    cyc(1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 8; k++) cyc(1'b0, 2'd0, 1'b0, 1'b1, 8'hAA);
    chk("sat_err", 64'(o_err_count), 64'(ERR_MAX));
    chk("sat_pass", 64'(o_pass), 64'd0);

    // Simultaneous ack/valid, then restart mid-run
    cyc(1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) cyc(1'b0, 2'd0, 1'b1, 1'b1, 8'(k));
    chk("both_tx", 64'(o_tx_byte), 64'h04);
    chk("both_rx", 64'(o_rx_count), 64'd4);
    cyc(1'b1, 2'd2, 1'b1, 1'b1, 8'h04);
    chk("restart_rx", 64'(o_rx_count), 64'd0);
    chk("restart_tx", 64'(o_tx_byte), 64'h10);
    chk("restart_done", 64'(o_done), 64'd0);
    chk("restart_busy", 64'(o_busy), 64'd1);

    // Asynchronous reset mid-run
    cyc(1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) cyc(1'b0, 2'd0, 1'b1, 1'b1, 8'(k));
    chk("pre_rst_rx", 64'(o_rx_count), 64'd5);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_all_zero("async_rst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 2'd0, 1'b0, 1'b1, 8'h00);
      chk("post_rst_done", 64'(o_done), 64'd0);
    end

    // Random traffic, mostly-correct read-back
    for (int n = 0; n < 3000; n++) begin
      logic st, ack, rv;
      logic [7:0] rb;
      st  = ($urandom_range(39) == 0);
      ack = $urandom_range(1);
      rv  = $urandom_range(1);
      rb  = ($urandom_range(9) == 0) ? 8'($urandom) : seq_byte(m_sel, m_rx_n);
      cyc(st, 2'($urandom_range(3)), ack, rv, rb);
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sf_pattern_engine.md
SF_PATTERN_ENGINE -- requirements
Module: sf_pattern_engine

Interface
REQ-001 SHALL have parameter P_CHECK_LEN, default 1048576, meaning the number of bytes checked per run; the legal range is 1 to 2^32-1.
REQ-002 SHALL have parameter P_ERR_CNT_W, default 32, meaning the width of the error counter.
REQ-003 SHALL have port i_clk_40mhz, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rstn_40mhz, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_pattern_sel, input, 2 bits: selects pattern 0=A, 1=B, 2=C, 3=D.
REQ-006 SHALL have port i_start, input, 1 bit: single-cycle pulse that arms a run.
REQ-007 SHALL have port i_tx_ack, input, 1 bit: the page-program stage consumed o_tx_byte.
REQ-008 SHALL have port o_tx_byte, output, 8 bits: the next byte to program.
REQ-009 SHALL have port i_rx_valid, input, 1 bit: i_rx_byte holds a byte read back from flash.
REQ-010 SHALL have port i_rx_byte, input, 8 bits: the read-back data.
REQ-011 SHALL have port o_busy, output, 1 bit: high while in ST_ACTIVE.
REQ-012 SHALL have port o_done, output, 1 bit: single-cycle pulse when the check completes.
REQ-013 SHALL have port o_pass, output, 1 bit: high when the last completed run had zero errors.
REQ-014 SHALL have port o_err_count, output, P_ERR_CNT_W bits: the mismatch count.
REQ-015 SHALL have port o_rx_count, output, 32 bits: the number of bytes checked.
REQ-016 SHALL have port o_first_err_idx, output, 32 bits: the rx index of the first mismatch.
REQ-017 SHALL have port o_first_err_exp, output, 8 bits: the expected byte at the first mismatch.
REQ-018 SHALL have port o_first_err_act, output, 8 bits: the actual byte at the first mismatch.

Function
REQ-019 SHALL use the pattern table (start, increment): A = 0x00, 0x01; B = 0x08, 0x07; C = 0x10, 0x0F; D = 0x18, 0x17.
REQ-020 SHALL implement FSM states ST_IDLE, ST_ACTIVE and ST_DONE.
REQ-021 SHALL go from ST_IDLE or ST_DONE to ST_ACTIVE on i_start, and on that edge SHALL:
- latch i_pattern_sel;
- load the tx generator and the rx expected register with the selected start value;
- clear o_err_count, o_rx_count and the first-error capture.
REQ-022 SHALL, on i_start while in ST_ACTIVE, restart exactly as in REQ-021, and SHALL NOT pulse o_done.
REQ-023 SHALL drive o_tx_byte combinationally from the tx generator register, which is valid in every state.
REQ-024 SHALL, in ST_ACTIVE on i_tx_ack, advance the tx generator by the latched increment modulo 256, visible on the next cycle; i_tx_ack SHALL be ignored outside ST_ACTIVE.
REQ-025 SHALL, in ST_ACTIVE on i_rx_valid:
- compare i_rx_byte against the expected register;
- advance the expected register by the increment modulo 256;
- increment o_rx_count.
i_rx_valid SHALL be ignored outside ST_ACTIVE.
REQ-026 SHALL increment o_err_count on each mismatch, saturating at all-ones with no wrap.
REQ-027 SHALL run the tx and rx paths independently; i_tx_ack and i_rx_valid in the same cycle SHALL both take effect.
REQ-028 SHALL NOT reload the generators at page boundaries; the sequence is continuous across the whole run.
REQ-029 SHALL, on the i_rx_valid that makes the checked count reach P_CHECK_LEN, go to ST_DONE on the next edge, pulse o_done for one cycle, and update o_pass.
REQ-030 SHALL set o_pass to the reduction-NOR of o_err_count including the final byte's compare result; o_pass SHALL hold until the next completion or reset.
REQ-031 SHALL give each counter and register update a latency of one clock edge from the qualifying input.

Reset
REQ-032 SHALL, while i_rstn_40mhz is low, immediately force:
- state ST_IDLE;
- tx generator and expected register to 0x00;
- all counters and captures to 0;
- o_busy, o_done and o_pass to 0.
REQ-033 SHALL, on reset assertion mid-run, abort the run with no o_done pulse.

Configuration
REQ-034 SHALL, with SF_PATTERN_FIRST_ERR_CAPTURE_EN defined, capture index, expected and actual on the first mismatch of a run and hold them until the next i_start or reset.
REQ-035 SHALL, without SF_PATTERN_FIRST_ERR_CAPTURE_EN, tie o_first_err_idx, o_first_err_exp and o_first_err_act to 0 and instantiate no capture registers.

Verification
REQ-036 With P_CHECK_LEN=8, pattern A, 8 acks -> o_tx_byte steps 00,01,02,...,07.
REQ-037 With P_CHECK_LEN=8, pattern A, rx bytes 00..07 -> one o_done pulse one cycle after the 8th valid, o_pass=1, o_err_count=0, o_rx_count=8.
REQ-038 With pattern D, 12 acks -> bytes 18,2F,46,5D,74,8B,A2,B9,D0,E7,FE,15 (wraps past 0xFF).
REQ-039 With pattern B, rx sequence 08,0F,FF,1D and P_CHECK_LEN=4 -> err_count=1, o_pass=0; with the macro defined, first_err = idx 2, exp 0x16, act 0xFF.
REQ-040 i_tx_ack and i_rx_valid held high together for 4 cycles -> both paths advance by 4; then i_start mid-run -> counters cleared, no o_done.
REQ-041 Reset asserted with o_rx_count=5 -> all outputs 0 and state ST_IDLE without waiting for a clock edge; no o_done after release.
